// File: rtl/matrix_store_writer_pkg.sv
// Shared definitions for the matrix storage path: writer FSM states and the
// 3-word slot header layout that the selector and reader decode the same way.
package matrix_storage_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    HDR0,
    HDR1,
    HDR2,
    DATA,
    DONE
  } store_state_t;

  localparam int HDR_WORDS     = 3;
  localparam int HDR_DIM_OFS   = 0;
  localparam int HDR_NAME0_OFS = 1;
  localparam int HDR_NAME1_OFS = 2;

  // Header word 0 carries the dimensions, rows in the upper byte of the low half.
  function automatic logic [31:0] hdr_dim_word(input logic [7:0] rows,
                                               input logic [7:0] cols);
    return {16'h0000, rows, cols};
  endfunction

  // Name words put the lowest-numbered byte in the MSBs.
  function automatic logic [31:0] hdr_name_word(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2,
                                                input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/matrix_store_writer_if.sv
// Request/data handshake between the compute-side storage manager (master)
// and the matrix store writer (slave).
interface matrix_store_writer_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  write_request;
  logic                  write_ready;
  logic [2:0]            write_matrix_id;
  logic [7:0]            write_rows;
  logic [7:0]            write_cols;
  logic [0:7][7:0]       write_name;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_data_valid;
  logic                  writer_ready;
  logic                  write_done;
  logic                  write_error;

  modport master (
    output write_request, write_matrix_id, write_rows, write_cols, write_name,
           write_data, write_data_valid,
    input  write_ready, writer_ready, write_done, write_error
  );

  modport slave (
    input  write_request, write_matrix_id, write_rows, write_cols, write_name,
           write_data, write_data_valid,
    output write_ready, writer_ready, write_done, write_error
  );

endinterface

// File: rtl/matrix_store_writer_slot_base_calc.sv
// Registered slot base address. It loads on the same edge that accepts a
// request, so the base is already stable while the request is being checked
// and can address the first header word directly.
module slot_base_calc #(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [2:0]            id,
  output logic [ADDR_WIDTH-1:0] base
);

  // Capture id x BLOCK_SIZE, truncated to the BRAM address width.
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
    end else if (load) begin
      base <= ADDR_WIDTH'(32'(id) * 32'(BLOCK_SIZE));
    end
  end

endmodule

// File: rtl/matrix_store_writer.sv
// Storage-side write engine: validates a result-matrix write request, writes
// the 3-word header into the slot, streams the element words after it and
// keeps a per-slot valid bitmap for the selector and display logic.
module matrix_store_writer
  import matrix_storage_pkg::*;
#(
  parameter int BLOCK_SIZE = 1152,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_SLOTS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_store_writer_if.slave   wr,
  output logic                   bram_wr_en,
  output logic [ADDR_WIDTH-1:0]  bram_wr_addr,
  output logic [DATA_WIDTH-1:0]  bram_wr_data,
  output logic [NUM_SLOTS-1:0]   slot_valid
);

  store_state_t          state;
  logic [2:0]            id_q;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [0:7][7:0]       name_q;
  logic [15:0]           total_q;
  logic [15:0]           count_q;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  base_load;
  logic [15:0]           total_calc;
  logic                  reject;

  assign base_load  = (state == IDLE) && wr.write_request;
  assign total_calc = 16'(rows_q) * 16'(cols_q);
  assign reject     = (rows_q == 8'd0) || (cols_q == 8'd0) ||
                      (32'(total_calc) > 32'(BLOCK_SIZE - HDR_WORDS)) ||
                      (32'(id_q) >= 32'(NUM_SLOTS));

  slot_base_calc #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_slot_base_calc (
    .clk  (clk),
    .rst  (rst),
    .load (base_load),
    .id   (wr.write_matrix_id),
    .base (base_addr)
  );

  // Single FSM with registered handshake, BRAM port and valid bitmap; the
  // write strobe and status pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      id_q            <= '0;
      rows_q          <= '0;
      cols_q          <= '0;
      name_q          <= '0;
      total_q         <= '0;
      count_q         <= '0;
      wr.write_ready  <= 1'b1;
      wr.writer_ready <= 1'b0;
      wr.write_done   <= 1'b0;
      wr.write_error  <= 1'b0;
      bram_wr_en      <= 1'b0;
      bram_wr_addr    <= '0;
      bram_wr_data    <= '0;
      slot_valid      <= '0;
    end else begin
      bram_wr_en     <= 1'b0;
      wr.write_done  <= 1'b0;
      wr.write_error <= 1'b0;
      case (state)
        IDLE: begin
          if (wr.write_request) begin
            id_q           <= wr.write_matrix_id;
            rows_q         <= wr.write_rows;
            cols_q         <= wr.write_cols;
            name_q         <= wr.write_name;
            wr.write_ready <= 1'b0;
            state          <= CHECK;
          end
        end
        CHECK: begin
          total_q <= total_calc;
          count_q <= '0;
          if (reject) begin
            wr.write_error <= 1'b1;
            wr.write_ready <= 1'b1;
            state          <= IDLE;
          end else begin
            slot_valid[id_q] <= 1'b0;
            bram_wr_en       <= 1'b1;
            bram_wr_addr     <= base_addr + ADDR_WIDTH'(HDR_DIM_OFS);
            bram_wr_data     <= DATA_WIDTH'(hdr_dim_word(rows_q, cols_q));
            state            <= HDR0;
          end
        end
        HDR0: begin
          bram_wr_en   <= 1'b1;
          bram_wr_addr <= base_addr + ADDR_WIDTH'(HDR_NAME0_OFS);
          bram_wr_data <= DATA_WIDTH'(hdr_name_word(name_q[0], name_q[1],
                                                    name_q[2], name_q[3]));
          state        <= HDR1;
        end
        HDR1: begin
          bram_wr_en   <= 1'b1;
          bram_wr_addr <= base_addr + ADDR_WIDTH'(HDR_NAME1_OFS);
          bram_wr_data <= DATA_WIDTH'(hdr_name_word(name_q[4], name_q[5],
                                                    name_q[6], name_q[7]));
          state        <= HDR2;
        end
        HDR2: begin
          wr.writer_ready <= 1'b1;
          state           <= DATA;
        end
        DATA: begin
          if (wr.write_data_valid) begin
            bram_wr_en   <= 1'b1;
            bram_wr_addr <= base_addr + ADDR_WIDTH'(HDR_WORDS) + ADDR_WIDTH'(count_q);
            bram_wr_data <= wr.write_data;
            count_q      <= count_q + 16'd1;
            if (count_q + 16'd1 == total_q) begin
              wr.writer_ready <= 1'b0;
              wr.write_done   <= 1'b1;
              state           <= DONE;
            end
          end
        end
        DONE: begin
          slot_valid[id_q] <= 1'b1;
          wr.write_ready   <= 1'b1;
          state            <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
